// File: rtl/clrec_decoder.sv
// Expands code-length-code records (symbols 0..18 + extra bits) into the flat
// litlen/dist code-length table, issuing one code-length RAM write per clock.
module clrec_decoder #(
    parameter int MAX_CODES = 320,
    parameter int ADDR_W    = 9,
    parameter int CL_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] total_count,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [4:0]        sym,
    input  logic [6:0]        sym_extra,
    output logic              cl_we,
    output logic [ADDR_W-1:0] cl_addr,
    output logic [CL_W-1:0]   cl_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Overrun sum needs room for a full counter plus the longest run (138).
    localparam int SUM_A = ADDR_W + 1;
    localparam int SUM_B = $clog2(MAX_CODES + 139);
    localparam int SUM_W = (SUM_A > SUM_B) ? SUM_A : SUM_B;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        REPEAT,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic [CL_W-1:0] len;
        logic [7:0]      cnt;
        logic            bad;
    } run_t;

    state_t            st, st_n;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_n;
    logic [ADDR_W-1:0] rep_cnt, rep_cnt_n;
    logic [ADDR_W-1:0] total, total_n;
    logic [CL_W-1:0]   prev_len, prev_len_n;
    logic              prev_valid, prev_valid_n;
    logic              we_n, done_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [CL_W-1:0]   data_n;
    run_t              run;
    logic              fits;
    logic              last_wr;

    always_comb begin
        run = '0;
        if (sym <= 5'd15) begin
            run.len = CL_W'(sym);
            run.cnt = 8'd1;
        end else begin
            case (sym)
                5'd16: begin
                    run.len = prev_len;
                    run.cnt = 8'd3 + {6'd0, sym_extra[1:0]};
                    run.bad = !prev_valid;
                end
                5'd17: run.cnt = 8'd3 + {5'd0, sym_extra[2:0]};
                5'd18: run.cnt = 8'd11 + {1'b0, sym_extra};
                default: run.bad = 1'b1;
            endcase
        end
    end

    // Whole run must fit; a run that would overrun is rejected before any write.
    assign fits    = (SUM_W'(wr_cnt) + SUM_W'(run.cnt)) <= SUM_W'(total);
    assign last_wr = (wr_cnt + ADDR_W'(1)) == total;

    assign sym_ready = (st == ACCEPT);
    assign busy      = (st == ACCEPT) || (st == REPEAT);

    always_comb begin
        st_n         = st;
        wr_cnt_n     = wr_cnt;
        rep_cnt_n    = rep_cnt;
        total_n      = total;
        prev_len_n   = prev_len;
        prev_valid_n = prev_valid;
        we_n         = 1'b0;
        addr_n       = cl_addr;
        data_n       = cl_data;
        done_n       = 1'b0;
        err_n        = error;

        if (start) begin
            st_n         = (total_count == '0) ? DONE : ACCEPT;
            done_n       = (total_count == '0);
            wr_cnt_n     = '0;
            rep_cnt_n    = '0;
            total_n      = total_count;
            prev_len_n   = '0;
            prev_valid_n = 1'b0;
            err_n        = 1'b0;
        end else begin
            case (st)
                ACCEPT: begin
                    if (sym_valid) begin
                        if (run.bad || !fits) begin
                            st_n  = ERROR;
                            err_n = 1'b1;
                        end else begin
                            we_n         = 1'b1;
                            addr_n       = wr_cnt;
                            data_n       = run.len;
                            wr_cnt_n     = wr_cnt + ADDR_W'(1);
                            prev_len_n   = run.len;
                            prev_valid_n = 1'b1;
                            if (last_wr) begin
                                done_n = 1'b1;
                                st_n   = DONE;
                            end else if (run.cnt > 8'd1) begin
                                st_n      = REPEAT;
                                rep_cnt_n = ADDR_W'(run.cnt - 8'd1);
                            end
                        end
                    end
                end
                REPEAT: begin
                    we_n      = 1'b1;
                    addr_n    = wr_cnt;
                    data_n    = prev_len;
                    wr_cnt_n  = wr_cnt + ADDR_W'(1);
                    rep_cnt_n = rep_cnt - ADDR_W'(1);
                    if (last_wr) begin
                        done_n = 1'b1;
                        st_n   = DONE;
                    end else if (rep_cnt == ADDR_W'(1)) begin
                        st_n = ACCEPT;
                    end
                end
                DONE:    st_n = IDLE;
                default: st_n = st;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            wr_cnt     <= '0;
            rep_cnt    <= '0;
            total      <= '0;
            prev_len   <= '0;
            prev_valid <= 1'b0;
            cl_we      <= 1'b0;
            cl_addr    <= '0;
            cl_data    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            st         <= st_n;
            wr_cnt     <= wr_cnt_n;
            rep_cnt    <= rep_cnt_n;
            total      <= total_n;
            prev_len   <= prev_len_n;
            prev_valid <= prev_valid_n;
            cl_we      <= we_n;
            cl_addr    <= addr_n;
            cl_data    <= data_n;
            done       <= done_n;
            error      <= err_n;
        end
    end

endmodule

// File: tb/tb_clrec_decoder.sv
// Directed and random record streams against a table-building reference model.
module tb_clrec_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [8:0] total_count = '0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [4:0] sym = '0;
    logic [6:0] sym_extra = '0;
    logic       cl_we;
    logic [8:0] cl_addr;
    logic [3:0] cl_data;
    logic       busy, done, error;

    clrec_decoder dut (
        .clk(clk), .reset(reset), .start(start), .total_count(total_count),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym(sym), .sym_extra(sym_extra),
        .cl_we(cl_we), .cl_addr(cl_addr), .cl_data(cl_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done log, sampled mid-cycle.
    int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
    int done_cnt = 0, done_cyc = -1, rdy_wr_cnt = 0;
    always @(negedge clk) begin
        if (cl_we) begin
            wr_addr_q.push_back(int'(cl_addr));
            wr_data_q.push_back(int'(cl_data));
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (cl_we && sym_ready) rdy_wr_cnt = rdy_wr_cnt + 1;
    end

    int n_assert = 0, n_fail = 0;
    int base_w = 0, base_d = 0, base_r = 0;

    // Reference model: the expected table as a plain list of lengths.
    int mq[$];
    int mprev;
    int merr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mprev = -1;
        merr  = 0;
    endtask

    task automatic model_step(input int s, input int e, input int total);
        int cnt, len;
        if (merr != 0) return;
        cnt = (s == 16) ? 3 + (e % 4) : (s == 17) ? 3 + (e % 8) : (s == 18) ? 11 + (e % 128) : 1;
        if (s > 18 || (s == 16 && mprev < 0)) begin
            merr = 1;
        end else begin
            len = (s <= 15) ? s : (s == 16) ? mprev : 0;
            if (mq.size() + cnt > total) merr = 1;
            else begin
                repeat (cnt) mq.push_back(len);
                mprev = len;
            end
        end
    endtask

    task automatic do_start(input int t);
        start = 1'b1;
        total_count = t[8:0];
        base_w = wr_addr_q.size();
        base_d = done_cnt;
        base_r = rdy_wr_cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int s, input int e, output int acc);
        int g = 0;
        sym_valid = 1'b1;
        sym = s[4:0];
        sym_extra = e[6:0];
        while (!sym_ready && g < 400) begin
            tick();
            g++;
        end
        if (!sym_ready) begin
            chk("ready_timeout", sym_ready, 1);
            acc = -1;
        end else begin
            acc = cyc;
            tick();
        end
        sym_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (busy && g < 400) begin
            tick();
            g++;
        end
        chk("drain_busy", busy, 0);
        tick();
    endtask

    task automatic check_run(input string tag, input int total);
        int n = wr_addr_q.size() - base_w;
        int edone = (merr == 0 && mq.size() == total) ? 1 : 0;
        chk({tag, " nwr"}, n, mq.size());
        for (int i = 0; i < n && i < mq.size(); i++) begin
            chk({tag, " addr"}, wr_addr_q[base_w+i], i);
            chk({tag, " data"}, wr_data_q[base_w+i], mq[i]);
        end
        chk({tag, " error"}, error, merr);
        chk({tag, " done_cnt"}, done_cnt - base_d, edone);
        if (edone == 1 && n > 0)
            chk({tag, " done_cyc"}, done_cyc, wr_cyc_q[wr_cyc_q.size()-1]);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc0, t, s, e, r;

        // Reset state
        tick();
        chk("rst sym_ready", sym_ready, 0);
        chk("rst cl_we", cl_we, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst cl_addr", cl_addr, 0);
        chk("rst cl_data", cl_data, 0);
        reset = 1'b1;
        tick();

        // Literal lengths, one write per record, first write one cycle after accept
        model_reset();
        do_start(4);
        chk("t1 busy", busy, 1);
        send(8, 0, acc0); model_step(8, 0, 4);
        send(8, 0, acc);  model_step(8, 0, 4);
        send(0, 0, acc);  model_step(0, 0, 4);
        send(5, 0, acc);  model_step(5, 0, 4);
        drain();
        check_run("t1", 4);
        if (wr_cyc_q.size() > base_w) chk("t1 first_cyc", wr_cyc_q[base_w], acc0 + 1);
        chk("t1 busy_after", busy, 0);

        // Repeat-previous expands without a gap
        model_reset();
        do_start(7);
        send(7, 0, acc);  model_step(7, 0, 7);
        send(16, 3, acc); model_step(16, 3, 7);
        drain();
        check_run("t2", 7);
        if (wr_cyc_q.size() - base_w == 7)
            chk("t2 span", wr_cyc_q[base_w+6] - wr_cyc_q[base_w], 6);

        // Longest zero run fills the table exactly; ready stays low during it
        model_reset();
        do_start(138);
        send(18, 127, acc); model_step(18, 127, 138);
        drain();
        check_run("t3", 138);
        chk("t3 ready_during_run", rdy_wr_cnt - base_r, 0);

        // Repeat with no previous length
        model_reset();
        do_start(5);
        send(16, 0, acc); model_step(16, 0, 5);
        tick();
        check_run("t4", 5);
        chk("t4 ready_in_error", sym_ready, 0);
        do_start(5);
        chk("t4 error_cleared", error, 0);

        // Overrun: the whole run is rejected
        model_reset();
        do_start(5);
        send(3, 0, acc);  model_step(3, 0, 5);
        send(17, 7, acc); model_step(17, 7, 5);
        tick();
        check_run("t5", 5);

        // Restart mid-repeat
        do_start(20);
        send(18, 0, acc);
        tick(); tick(); tick();
        model_reset();
        do_start(2);
        chk("t6 we_after_start", cl_we, 0);
        chk("t6 busy", busy, 1);
        send(4, 0, acc); model_step(4, 0, 2);
        send(6, 0, acc); model_step(6, 0, 2);
        drain();
        check_run("t6", 2);

        // Zero-entry table completes immediately
        model_reset();
        do_start(0);
        chk("t8 done", done, 1);
        chk("t8 busy", busy, 0);
        tick();
        chk("t8 done_pulse", done, 0);
        chk("t8 nwr", wr_addr_q.size() - base_w, 0);

        // Asynchronous reset mid-run
        do_start(30);
        send(18, 10, acc);
        tick(); tick(); tick();
        chk("t7 running", cl_we, 1);
        #2 reset = 1'b0;
        #1;
        chk("t7 cl_we", cl_we, 0);
        chk("t7 busy", busy, 0);
        chk("t7 sym_ready", sym_ready, 0);
        chk("t7 cl_addr", cl_addr, 0);
        chk("t7 cl_data", cl_data, 0);
        chk("t7 done", done, 0);
        chk("t7 error", error, 0);
        tick();
        reset = 1'b1;
        tick();

        // Random record streams
        for (int it = 0; it < 25; it++) begin
            t = $urandom_range(1, 40);
            model_reset();
            do_start(t);
            while (merr == 0 && mq.size() < t) begin
                r = $urandom_range(0, 99);
                if (r < 55)      s = $urandom_range(0, 15);
                else if (r < 75) s = 16;
                else if (r < 88) s = 17;
                else if (r < 96) s = 18;
                else             s = $urandom_range(19, 31);
                e = (s == 18) ? $urandom_range(0, 30) : $urandom_range(0, 127);
                model_step(s, e, t);
                send(s, e, acc);
            end
            drain();
            check_run("rnd", t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
